bus_reg_responder: RTL and testbench

- Module-side register responder sitting on one per-domain bus output of the CPU-to-module clock-domain crossing. Runs entirely in the destination clock domain.
- Decodes a window of word addresses, holds control registers, samples status inputs and latches sticky events. Returns registered read data to the crossing and can request CPU halt while read data settles.
- address_width and data_width come from cpu_reg_package.

---
 rtl/bus_reg_responder.sv | 214 +++++++++++++++++++++
 tb/tb_bus_reg_responder.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/bus_reg_responder.sv
// Register responder on one destination-domain bus port: control, status, sticky event, mask and ID registers.
// Optional macro BUS_REG_RESPONDER_WAIT_EN adds a 1-cycle halt_o stall on each new in-window address.

package cpu_reg_package;
  localparam int unsigned address_width = 16;
  localparam int unsigned data_width    = 32;
endpackage

module bus_reg_responder
  import cpu_reg_package::*;
#(
  // Must be a multiple of 16 so the window is selected by the upper address bits alone.
  parameter logic [address_width-1:0] BASE_ADDRESS     = '0,
  parameter int unsigned              NUM_CTRL_REGS    = 4,
  parameter int unsigned              NUM_STAT_REGS    = 4,
  parameter logic [data_width-1:0]    CTRL_RESET_VALUE = '0
) (
  input  logic                                 clk_i,
  input  logic                                 reset_n_i,
  input  logic [address_width-1:0]             address_i,
  input  logic                                 we_i,
  input  logic [data_width-1:0]                data_i,
  output logic [data_width-1:0]                data_o,
  output logic                                 halt_o,
  output logic [NUM_CTRL_REGS*data_width-1:0]  ctrl_o,
  output logic [NUM_CTRL_REGS-1:0]             ctrl_wr_stb_o,
  input  logic [NUM_STAT_REGS*data_width-1:0]  stat_i,
  input  logic [data_width-1:0]                event_i,
  output logic                                 irq_o
);

  localparam logic [3:0] OFF_STICKY = 4'd12;
  localparam logic [3:0] OFF_MASK   = 4'd13;
  localparam logic [31:0] ID_RAW = {16'hB5E0, 8'(NUM_CTRL_REGS), 8'(NUM_STAT_REGS)};
  localparam logic [data_width-1:0] ID_VALUE = data_width'(ID_RAW);

  logic [data_width-1:0]    ctrl_q      [NUM_CTRL_REGS];
  logic [data_width-1:0]    stat_meta_q [NUM_STAT_REGS];
  logic [data_width-1:0]    stat_sync_q [NUM_STAT_REGS];
  logic [data_width-1:0]    ev_meta_q;
  logic [data_width-1:0]    ev_sync_q;
  logic [data_width-1:0]    ev_prev_q;
  logic [data_width-1:0]    sticky_q;
  logic [data_width-1:0]    mask_q;

  logic                     in_window_c;
  logic [3:0]               offset_c;
  logic                     wr_c;
  logic [NUM_CTRL_REGS-1:0] ctrl_wr_c;
  logic [data_width-1:0]    sticky_clr_c;
  logic [data_width-1:0]    ev_rise_c;
  logic [data_width-1:0]    rd_data_c;

  // Window decode relies on BASE_ADDRESS alignment.
  assign in_window_c  = (address_i[address_width-1:4] == BASE_ADDRESS[address_width-1:4]);
  assign offset_c     = address_i[3:0];
  assign wr_c         = we_i & in_window_c;
  assign sticky_clr_c = (wr_c && (offset_c == OFF_STICKY)) ? data_i : '0;
  assign ev_rise_c    = ev_sync_q & ~ev_prev_q;

  // Per-register write enables; unimplemented control slots never match.
  always_comb begin
    ctrl_wr_c = '0;
    for (int unsigned i = 0; i < NUM_CTRL_REGS; i++) begin
      if (wr_c && !offset_c[3] && (offset_c[2:0] == 3'(i))) begin
        ctrl_wr_c[i] = 1'b1;
      end
    end
  end

  // Read mux; anything unimplemented or outside the window reads 0.
  always_comb begin
    rd_data_c = '0;
    if (in_window_c) begin
      if (!offset_c[3]) begin
        for (int unsigned i = 0; i < NUM_CTRL_REGS; i++) begin
          if (offset_c[2:0] == 3'(i)) begin
            rd_data_c = ctrl_q[i];
          end
        end
      end else begin
        case (offset_c[2:0])
          3'd4:    rd_data_c = sticky_q;
          3'd5:    rd_data_c = mask_q;
          3'd6:    rd_data_c = ID_VALUE;
          3'd7:    rd_data_c = '0;
          default: begin
            for (int unsigned i = 0; i < NUM_STAT_REGS; i++) begin
              if (offset_c[1:0] == 2'(i)) begin
                rd_data_c = stat_sync_q[i];
              end
            end
          end
        endcase
      end
    end
  end

  // Control registers and their one-cycle write strobes.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int unsigned i = 0; i < NUM_CTRL_REGS; i++) begin
        ctrl_q[i] <= CTRL_RESET_VALUE;
      end
      ctrl_wr_stb_o <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_CTRL_REGS; i++) begin
        if (ctrl_wr_c[i]) begin
          ctrl_q[i] <= data_i;
        end
      end
      ctrl_wr_stb_o <= ctrl_wr_c;
    end
  end

  for (genvar g = 0; g < NUM_CTRL_REGS; g++) begin : g_ctrl_out
    assign ctrl_o[g*data_width +: data_width] = ctrl_q[g];
  end

  // Status synchronisers.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int unsigned i = 0; i < NUM_STAT_REGS; i++) begin
        stat_meta_q[i] <= '0;
        stat_sync_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_STAT_REGS; i++) begin
        stat_meta_q[i] <= stat_i[i*data_width +: data_width];
        stat_sync_q[i] <= stat_meta_q[i];
      end
    end
  end

  // Event synchroniser, edge detect, sticky (set beats clear) and mask.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      ev_meta_q <= '0;
      ev_sync_q <= '0;
      ev_prev_q <= '0;
      sticky_q  <= '0;
      mask_q    <= '0;
    end else begin
      ev_meta_q <= event_i;
      ev_sync_q <= ev_meta_q;
      ev_prev_q <= ev_sync_q;
      sticky_q  <= (sticky_q & ~sticky_clr_c) | ev_rise_c;
      if (wr_c && (offset_c == OFF_MASK)) begin
        mask_q <= data_i;
      end
    end
  end

  // Registered read data and interrupt.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      data_o <= '0;
      irq_o  <= 1'b0;
    end else begin
      data_o <= rd_data_c;
      irq_o  <= |(sticky_q & mask_q);
    end
  end

`ifdef BUS_REG_RESPONDER_WAIT_EN
  typedef enum logic {IDLE, WAIT} state_t;

  state_t                   state_q;
  state_t                   state_d;
  logic [address_width-1:0] prev_addr_q;
  logic                     primed_q;
  logic                     new_addr_c;
  logic                     halt_c;

  // primed_q is clear only in the first cycle after reset, so that cycle counts as a new address.
  assign new_addr_c = in_window_c && (!primed_q || (address_i != prev_addr_q));

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= IDLE;
      prev_addr_q <= '0;
      primed_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      prev_addr_q <= address_i;
      primed_q    <= 1'b1;
    end
  end

  // A different address arriving during WAIT is stalled for its own cycle as well.
  always_comb begin
    state_d = state_q;
    halt_c  = 1'b0;
    case (state_q)
      IDLE: begin
        if (new_addr_c) begin
          state_d = WAIT;
          halt_c  = 1'b1;
        end
      end
      WAIT: begin
        state_d = IDLE;
        halt_c  = new_addr_c;
      end
      default: state_d = IDLE;
    endcase
  end

  assign halt_o = halt_c;
`else
  assign halt_o = 1'b0;
`endif

endmodule

// File: tb/tb_bus_reg_responder.sv
// Directed bench for bus_reg_responder: vector table for bus accesses plus hand sequences for sync/event/halt timing.
module tb_bus_reg_responder;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [15:0]   address;
  logic          we;
  logic [31:0]   wdata;
  logic [31:0]   data_o;
  logic          halt_o;
  logic [127:0]  ctrl_o;
  logic [3:0]    ctrl_wr_stb_o;
  logic [127:0]  stat_i;
  logic [31:0]   event_i;
  logic          irq_o;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  bus_reg_responder #(
    .BASE_ADDRESS     (16'h0040),
    .NUM_CTRL_REGS    (4),
    .NUM_STAT_REGS    (4),
    .CTRL_RESET_VALUE (32'h0000_005A)
  ) dut (
    .clk_i         (clk),
    .reset_n_i     (reset_n),
    .address_i     (address),
    .we_i          (we),
    .data_i        (wdata),
    .data_o        (data_o),
    .halt_o        (halt_o),
    .ctrl_o        (ctrl_o),
    .ctrl_wr_stb_o (ctrl_wr_stb_o),
    .stat_i        (stat_i),
    .event_i       (event_i),
    .irq_o         (irq_o)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [15:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic [3:0]  exp_stb;
  } vec_t;

  localparam int NV = 23;
  vec_t vecs [NV];

  localparam logic [127:0] CTRL_RST = {4{32'h0000_005A}};
  localparam logic [31:0]  ID_EXP   = 32'hB5E0_0404;

  logic h0, h1, h2;

  initial begin
    // Each entry: access presented for one cycle; exp_rd is data_o one edge later (pre-write value on writes).
    vecs[0]  = '{16'h0040, 1'b0, 32'h0,         32'h0000_005A, 4'b0000};
    vecs[1]  = '{16'h0042, 1'b1, 32'hDEADBEEF,  32'h0000_005A, 4'b0100};
    vecs[2]  = '{16'h0042, 1'b0, 32'h0,         32'hDEADBEEF,  4'b0000};
    vecs[3]  = '{16'h0040, 1'b1, 32'h1111_1111, 32'h0000_005A, 4'b0001};
    vecs[4]  = '{16'h0043, 1'b1, 32'h2222_2222, 32'h0000_005A, 4'b1000};
    vecs[5]  = '{16'h0043, 1'b0, 32'h0,         32'h2222_2222, 4'b0000};
    vecs[6]  = '{16'h0040, 1'b0, 32'h0,         32'h1111_1111, 4'b0000};
    vecs[7]  = '{16'h0047, 1'b0, 32'h0,         32'h0,         4'b0000};
    vecs[8]  = '{16'h0047, 1'b1, 32'hFFFF_FFFF, 32'h0,         4'b0000};
    vecs[9]  = '{16'h004F, 1'b0, 32'h0,         32'h0,         4'b0000};
    vecs[10] = '{16'h0050, 1'b1, 32'h0000_FFFF, 32'h0,         4'b0000};
    vecs[11] = '{16'h003F, 1'b1, 32'h0000_FFFF, 32'h0,         4'b0000};
    vecs[12] = '{16'h0050, 1'b0, 32'h0,         32'h0,         4'b0000};
    vecs[13] = '{16'h003F, 1'b0, 32'h0,         32'h0,         4'b0000};
    vecs[14] = '{16'h004E, 1'b0, 32'h0,         ID_EXP,        4'b0000};
    vecs[15] = '{16'h004E, 1'b1, 32'h0,         ID_EXP,        4'b0000};
    vecs[16] = '{16'h004E, 1'b0, 32'h0,         ID_EXP,        4'b0000};
    vecs[17] = '{16'h0048, 1'b1, 32'h0000_FFFF, 32'h0,         4'b0000};
    vecs[18] = '{16'h0048, 1'b0, 32'h0,         32'h0,         4'b0000};
    vecs[19] = '{16'h004D, 1'b1, 32'h3,         32'h0,         4'b0000};
    vecs[20] = '{16'h004D, 1'b0, 32'h0,         32'h3,         4'b0000};
    vecs[21] = '{16'h004D, 1'b1, 32'h1,         32'h3,         4'b0000};
    vecs[22] = '{16'h0041, 1'b0, 32'h0,         32'h0000_005A, 4'b0000};

    reset_n = 1'b0;
    address = 16'h0000;
    we      = 1'b0;
    wdata   = '0;
    stat_i  = '0;
    event_i = '0;

    repeat (2) @(negedge clk);
    check("rst_ctrl", ctrl_o, CTRL_RST);
    check("rst_data", 128'(data_o), 128'h0);
    check("rst_irq",  128'(irq_o), 128'h0);
    check("rst_halt", 128'(halt_o), 128'h0);
    check("rst_stb",  128'(ctrl_wr_stb_o), 128'h0);

    // Halt sequence BASE+0, BASE+1, BASE+1 starting on the first cycle after reset.
`ifdef BUS_REG_RESPONDER_WAIT_EN
    h0 = 1'b1; h1 = 1'b1; h2 = 1'b0;
`else
    h0 = 1'b0; h1 = 1'b0; h2 = 1'b0;
`endif
    reset_n = 1'b1;
    address = 16'h0040;
    #1 check("halt_c0", 128'(halt_o), 128'(h0));
    @(negedge clk); address = 16'h0041;
    #1 check("halt_c1", 128'(halt_o), 128'(h1));
    @(negedge clk);
    #1 check("halt_c2", 128'(halt_o), 128'(h2));

    @(negedge clk);
    for (int i = 0; i < NV; i++) begin
      address = vecs[i].addr;
      we      = vecs[i].we;
      wdata   = vecs[i].wdata;
      @(negedge clk);
      check($sformatf("vec%0d_rd", i),  128'(data_o), 128'(vecs[i].exp_rd));
      check($sformatf("vec%0d_stb", i), 128'(ctrl_wr_stb_o), 128'(vecs[i].exp_stb));
    end
    we = 1'b0;
    @(negedge clk);
    check("stb_idle", 128'(ctrl_wr_stb_o), 128'h0);
    check("ctrl_all", ctrl_o, {32'h2222_2222, 32'hDEADBEEF, 32'h0000_005A, 32'h1111_1111});

    // Status latency through the synchroniser.
    address = 16'h0049;
    stat_i[63:32] = 32'h0000_1234;
    @(negedge clk); check("stat_lat1", 128'(data_o), 128'h0);
    @(negedge clk); check("stat_lat2", 128'(data_o), 128'h0);
    @(negedge clk); check("stat_rd",   128'(data_o), 128'h1234);
    address = 16'h0048;
    @(negedge clk); check("stat0_rd",  128'(data_o), 128'h0);

    // Event sets sticky on the third edge, irq one edge later; then W1C clears it (mask = 1).
    address = 16'h004C;
    event_i = 32'h1;
    @(negedge clk); check("ev_a", 128'(data_o), 128'h0);
    @(negedge clk); check("ev_b", 128'(data_o), 128'h0);
    @(negedge clk); check("ev_c", 128'(data_o), 128'h0);
    check("ev_c_irq", 128'(irq_o), 128'h0);
    @(negedge clk); check("ev_sticky", 128'(data_o), 128'h1);
    check("ev_irq", 128'(irq_o), 128'h1);
    we = 1'b1; wdata = 32'h1;
    @(negedge clk); we = 1'b0; wdata = '0;
    @(negedge clk); check("w1c_sticky", 128'(data_o), 128'h0);
    check("w1c_irq", 128'(irq_o), 128'h0);

    // Rising edge on the same edge as the W1C: set wins.
    event_i = 32'h0;
    repeat (4) @(negedge clk);
    event_i = 32'h1;
    @(negedge clk);
    @(negedge clk); we = 1'b1; wdata = 32'h1;
    @(negedge clk); we = 1'b0; wdata = '0;
    @(negedge clk); check("setwin_sticky", 128'(data_o), 128'h1);
    check("setwin_irq", 128'(irq_o), 128'h1);

    // Reset asserted mid-write.
    address = 16'h0041; we = 1'b1; wdata = 32'hCAFE_F00D;
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_ctrl", ctrl_o, CTRL_RST);
    check("mid_rst_stb",  128'(ctrl_wr_stb_o), 128'h0);
    check("mid_rst_data", 128'(data_o), 128'h0);
    check("mid_rst_irq",  128'(irq_o), 128'h0);
    @(negedge clk);
    check("mid_rst_hold", ctrl_o, CTRL_RST);
    check("mid_rst_stb2", 128'(ctrl_wr_stb_o), 128'h0);
    we = 1'b0;
    reset_n = 1'b1;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
